// File: rtl/hyperbus_pkg.sv
// rtl/hyperbus_pkg.sv - shared types and widths for the HyperBus write serializer
//
// Purpose: FSM state encoding, bus width constants and the byte-lane helper
// used by hyperbus_tx_serializer.
// Ports: none (package).

package hyperbus_pkg;

  localparam int HB_WORD_W = 16;
  localparam int HB_DQ_W   = 8;
  localparam int HB_LEN_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } hb_state_t;

  // One DDR edge worth of bus content.
  typedef struct packed {
    logic [HB_DQ_W-1:0] dq;
    logic               rwds;
  } hb_lane_t;

  // RWDS is an active-high mask, the inverse of the byte enable. A missing
  // word is sent as a zero byte with the mask set so the memory keeps its
  // old contents.
  function automatic hb_lane_t hb_lane(input logic [HB_DQ_W-1:0] byte_in,
                                       input logic               strb_bit,
                                       input logic               valid);
    hb_lane_t lane;
    if (valid) begin
      lane.dq   = byte_in;
      lane.rwds = ~strb_bit;
    end else begin
      lane.dq   = '0;
      lane.rwds = 1'b1;
    end
    return lane;
  endfunction

endpackage

// File: rtl/hyperbus_tx_serializer.sv
// rtl/hyperbus_tx_serializer.sv - HyperBus write-data serializer, one DDR byte per clock
//
// Purpose: takes 16-bit write words with byte enables and emits them as a
// stream of DQ bytes (upper byte first) with the RWDS write mask and the
// paired CK level. clk_i runs at twice the CK rate; each cycle is one edge.
//
// Ports:
//   clk_i        system clock, one byte slot per cycle
//   rst_i        asynchronous active-high reset
//   start_i      single-cycle burst start, sampled only in IDLE
//   len_i        burst length in 16-bit words, latched on start
//   data_i       write word, [15:8] sent first
//   strb_i       byte enables, 1 = byte written
//   valid_i      data_i/strb_i valid
//   ready_o      word accepted when valid_i & ready_o
//   busy_o       burst in progress
//   done_o       single-cycle burst-complete pulse
//   underrun_o   sticky: a word slot had no valid data
//   hb_dq_o      DQ byte for the current edge
//   hb_dq_oe_o   DQ output enable
//   hb_rwds_o    write mask, 1 = byte masked
//   hb_rwds_oe_o RWDS output enable
//   hb_ck_o      CK level paired with hb_dq_o (1 = upper byte edge)

module hyperbus_tx_serializer
  import hyperbus_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [HB_LEN_W-1:0]  len_i,
  input  logic [HB_WORD_W-1:0] data_i,
  input  logic [1:0]           strb_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 underrun_o,
  output logic [HB_DQ_W-1:0]   hb_dq_o,
  output logic                 hb_dq_oe_o,
  output logic                 hb_rwds_o,
  output logic                 hb_rwds_oe_o,
  output logic                 hb_ck_o
);

  hb_state_t           r_state;
  logic [HB_LEN_W-1:0] r_cnt;
  logic [HB_DQ_W-1:0]  r_dq;
  logic                r_rwds;
  logic                r_ck;
  logic                r_oe;
  logic                r_busy;
  logic                r_done;
  logic                r_underrun;
  // Lower byte of the word taken in HI, held for the following LO edge.
  hb_lane_t            r_lo_lane;
  // Set while the final lower byte is on the bus; the FSM is already IDLE then.
  logic                r_tail;

  hb_lane_t            w_hi_lane;
  hb_lane_t            w_lo_lane;
  logic                w_last;

  assign w_hi_lane = hb_lane(data_i[HB_WORD_W-1:HB_DQ_W], strb_i[1], valid_i);
  assign w_lo_lane = hb_lane(data_i[HB_DQ_W-1:0],         strb_i[0], valid_i);
  assign w_last    = (r_cnt <= HB_LEN_W'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_dq       <= '0;
      r_rwds     <= 1'b0;
      r_ck       <= 1'b0;
      r_oe       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      r_lo_lane  <= '0;
      r_tail     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_tail) begin
            r_tail <= 1'b0;
            r_done <= 1'b1;
            r_busy <= 1'b0;
            r_oe   <= 1'b0;
            r_dq   <= '0;
            r_rwds <= 1'b0;
            r_ck   <= 1'b0;
          end
          if (start_i) begin
            r_underrun <= 1'b0;
            if (len_i == '0) begin
              r_done <= 1'b1;
            end else begin
              r_cnt   <= len_i;
              r_busy  <= 1'b1;
              r_state <= ST_HI;
            end
          end
        end

        ST_HI: begin
          // The slot is consumed whether or not a word is offered.
          r_state   <= ST_LO;
          r_oe      <= 1'b1;
          r_ck      <= 1'b1;
          r_dq      <= w_hi_lane.dq;
          r_rwds    <= w_hi_lane.rwds;
          r_lo_lane <= w_lo_lane;
          if (!valid_i) begin
            r_underrun <= 1'b1;
          end
        end

        ST_LO: begin
          r_ck   <= 1'b0;
          r_dq   <= r_lo_lane.dq;
          r_rwds <= r_lo_lane.rwds;
          r_cnt  <= (r_cnt != '0) ? (r_cnt - HB_LEN_W'(1)) : '0;
          if (w_last) begin
            r_state <= ST_IDLE;
            r_tail  <= 1'b1;
          end else begin
            r_state <= ST_HI;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready_o      = (r_state == ST_HI);
  assign busy_o       = r_busy;
  assign done_o       = r_done;
  assign underrun_o   = r_underrun;
  assign hb_dq_o      = r_dq;
  assign hb_dq_oe_o   = r_oe;
  assign hb_rwds_o    = r_rwds;
  assign hb_rwds_oe_o = r_oe;
  assign hb_ck_o      = r_ck;

endmodule

// File: tb/tb_hyperbus_tx_serializer.sv
// tb/tb_hyperbus_tx_serializer.sv - directed self-checking bench for hyperbus_tx_serializer

module tb_hyperbus_tx_serializer;

  logic        clk_i;
  logic        rst_i;
  logic        start_i;
  logic [15:0] len_i;
  logic [15:0] data_i;
  logic [1:0]  strb_i;
  logic        valid_i;
  logic        ready_o;
  logic        busy_o;
  logic        done_o;
  logic        underrun_o;
  logic [7:0]  hb_dq_o;
  logic        hb_dq_oe_o;
  logic        hb_rwds_o;
  logic        hb_rwds_oe_o;
  logic        hb_ck_o;

  int n_vec;
  int n_err;

  // Observed vector: {ready,busy,done,underrun, dq_oe,rwds_oe,ck,rwds, dq[7:0]}
  logic [15:0] obs;
  assign obs = {ready_o, busy_o, done_o, underrun_o,
                hb_dq_oe_o, hb_rwds_oe_o, hb_ck_o, hb_rwds_o, hb_dq_o};

  hyperbus_tx_serializer dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .start_i      (start_i),
    .len_i        (len_i),
    .data_i       (data_i),
    .strb_i       (strb_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .underrun_o   (underrun_o),
    .hb_dq_o      (hb_dq_o),
    .hb_dq_oe_o   (hb_dq_oe_o),
    .hb_rwds_o    (hb_rwds_o),
    .hb_rwds_oe_o (hb_rwds_oe_o),
    .hb_ck_o      (hb_ck_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; len_i = '0; data_i = '0; strb_i = '0; valid_i = 1'b0;
    #3;
    n_vec++;
    if (obs !== 16'h0000) begin n_err++; $display("FAIL reset_held obs=%h exp=%h", obs, 16'h0000); end
    tick();
    rst_i = 1'b0;
    tick();
    n_vec++;
    if (obs !== 16'h0000) begin n_err++; $display("FAIL reset_released obs=%h exp=%h", obs, 16'h0000); end
  endtask

  // len 2: A1B2 then C3D4, all bytes enabled
  task automatic test_nominal();
    logic [15:0] w [2] = '{16'hA1B2, 16'hC3D4};
    logic [15:0] e [7] = '{16'hC000, 16'h4EA1, 16'hCCB2, 16'h4EC3, 16'h4CD4, 16'h2000, 16'h0000};
    start_i = 1'b1; len_i = 16'd2; data_i = w[0]; strb_i = 2'b11; valid_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      start_i = 1'b0;
      n_vec++;
      if (obs !== e[c]) begin n_err++; $display("FAIL nominal c%0d obs=%h exp=%h", c + 1, obs, e[c]); end
      if ((c + 1) / 2 < 2) data_i = w[(c + 1) / 2];
    end
    valid_i = 1'b0;
  endtask

  // len 1: 1234 with only the lower byte enabled
  task automatic test_mask();
    logic [15:0] e [5] = '{16'hC000, 16'h4F12, 16'h4C34, 16'h2000, 16'h0000};
    start_i = 1'b1; len_i = 16'd1; data_i = 16'h1234; strb_i = 2'b01; valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      start_i = 1'b0;
      n_vec++;
      if (obs !== e[c]) begin n_err++; $display("FAIL mask c%0d obs=%h exp=%h", c + 1, obs, e[c]); end
    end
    valid_i = 1'b0;
  endtask

  // len 2: first word valid, second slot empty -> fully masked zero word
  task automatic test_underrun();
    logic [15:0] e [7] = '{16'hC000, 16'h4E55, 16'hCC66, 16'h5F00, 16'h5D00, 16'h3000, 16'h1000};
    start_i = 1'b1; len_i = 16'd2; data_i = 16'h5566; strb_i = 2'b11; valid_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      tick();
      start_i = 1'b0;
      n_vec++;
      if (obs !== e[c]) begin n_err++; $display("FAIL underrun c%0d obs=%h exp=%h", c + 1, obs, e[c]); end
      if (c == 1) valid_i = 1'b0;
    end
    tick();
    n_vec++;
    if (underrun_o !== 1'b1) begin n_err++; $display("FAIL underrun_sticky obs=%b exp=1", underrun_o); end
  endtask

  // len 0: done next cycle, no bus activity, accepted start clears underrun
  task automatic test_zero_length();
    start_i = 1'b1; len_i = 16'd0; valid_i = 1'b0;
    tick();
    start_i = 1'b0;
    n_vec++;
    if (obs !== 16'h2000) begin n_err++; $display("FAIL zero_len_done obs=%h exp=%h", obs, 16'h2000); end
    tick();
    n_vec++;
    if (obs !== 16'h0000) begin n_err++; $display("FAIL zero_len_after obs=%h exp=%h", obs, 16'h0000); end
  endtask

  // Reset after the upper byte of word 1 of a len 4 burst, then a clean len 1 burst
  task automatic test_mid_reset();
    logic [15:0] e [4] = '{16'hC000, 16'h4E22, 16'h4C33, 16'h2000};
    start_i = 1'b1; len_i = 16'd4; data_i = 16'h1111; strb_i = 2'b11; valid_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    n_vec++;
    if (obs !== 16'h4E11) begin n_err++; $display("FAIL midrst_upper obs=%h exp=%h", obs, 16'h4E11); end
    #2;
    rst_i = 1'b1;
    #1;
    n_vec++;
    if (obs !== 16'h0000) begin n_err++; $display("FAIL midrst_async obs=%h exp=%h", obs, 16'h0000); end
    tick();
    rst_i = 1'b0;
    n_vec++;
    if (obs !== 16'h0000) begin n_err++; $display("FAIL midrst_held obs=%h exp=%h", obs, 16'h0000); end
    start_i = 1'b1; len_i = 16'd1; data_i = 16'h2233;
    for (int c = 0; c < 4; c++) begin
      tick();
      start_i = 1'b0;
      n_vec++;
      if (obs !== e[c]) begin n_err++; $display("FAIL midrst_burst c%0d obs=%h exp=%h", c + 1, obs, e[c]); end
    end
    valid_i = 1'b0;
  endtask

  // Second start in the done cycle; starts while busy must not alter the burst
  task automatic test_back_to_back();
    logic [15:0] e [9] = '{16'hC000, 16'h4EAB, 16'h4CCD, 16'h2000,
                           16'hC000, 16'h4EEF, 16'h4C01, 16'h2000, 16'h0000};
    start_i = 1'b1; len_i = 16'd1; data_i = 16'hABCD; strb_i = 2'b11; valid_i = 1'b1;
    for (int c = 0; c < 9; c++) begin
      tick();
      start_i = 1'b0;
      n_vec++;
      if (obs !== e[c]) begin n_err++; $display("FAIL b2b c%0d obs=%h exp=%h", c + 1, obs, e[c]); end
      if (c == 0) begin start_i = 1'b1; len_i = 16'd5; end
      if (c == 1) begin start_i = 1'b1; len_i = 16'd7; end
      if (c == 3) begin start_i = 1'b1; len_i = 16'd1; data_i = 16'hEF01; end
    end
    valid_i = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_nominal();
    test_mask();
    test_underrun();
    test_zero_length();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
